// File: rtl/forward_stall_unit_pkg.sv
// Shared types and constants for the forwarding / stall unit and its scoreboard.
// Imported by the interface, the scoreboard and the top.
package forward_stall_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_S1 = 2'd1,
    FWD_S2 = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    SB_STALL = 2'd2
  } hazard_state_t;

  localparam int MC_LAT_MAX = 15;
  localparam int CNT_W      = 4;

  typedef logic [CNT_W-1:0] sb_cnt_t;

  // Saturating increment for the stall-cycle counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/forward_stall_unit_if.sv
// Bundle of decode/EX hazard signals between the pipeline and forward_stall_unit.
// The fu modport is the unit's view; the tb modport is the pipeline's (or bench's) view.
interface forward_stall_unit_if
  import forward_stall_unit_pkg::*;
#(
  parameter int REGBITS = 5,
  parameter int NSTAGES = 2,
  parameter int SELW    = $clog2(NSTAGES + 1)
);

  logic                       pipe_en;
  logic                       flush;
  logic [REGBITS-1:0]         ex_rs;
  logic [REGBITS-1:0]         ex_rt;
  logic [NSTAGES-1:0]         fwd_wen;
  logic [NSTAGES*REGBITS-1:0] fwd_reg;
  logic                       id_valid;
  logic [REGBITS-1:0]         id_rs;
  logic [REGBITS-1:0]         id_rt;
  logic [REGBITS-1:0]         id_rd;
  logic                       id_mc;
  logic                       ex_wen;
  logic                       ex_is_load;
  logic [REGBITS-1:0]         ex_rd;

  logic [SELW-1:0]            porta_sel;
  logic [SELW-1:0]            portb_sel;
  logic                       stall;
  logic                       sb_busy;
  logic [31:0]                stall_cycles;
  hazard_state_t              hz_state;

  modport fu (
    input  pipe_en, flush, ex_rs, ex_rt, fwd_wen, fwd_reg,
           id_valid, id_rs, id_rt, id_rd, id_mc, ex_wen, ex_is_load, ex_rd,
    output porta_sel, portb_sel, stall, sb_busy, stall_cycles, hz_state
  );

  modport tb (
    output pipe_en, flush, ex_rs, ex_rt, fwd_wen, fwd_reg,
           id_valid, id_rs, id_rt, id_rd, id_mc, ex_wen, ex_is_load, ex_rd,
    input  porta_sel, portb_sel, stall, sb_busy, stall_cycles, hz_state
  );

endinterface

// File: rtl/fwd_scoreboard.sv
// Per-register countdown scoreboard for fixed-latency multi-cycle results.
// A nonzero count means the register's value is still in flight.
module fwd_scoreboard
  import forward_stall_unit_pkg::*;
#(
  parameter int REGBITS = 5,
  parameter int MC_LAT  = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               pipe_en,
  input  logic               issue,
  input  logic [REGBITS-1:0] issue_rd,
  input  logic [REGBITS-1:0] rd_a,
  input  logic [REGBITS-1:0] rd_b,
  input  logic [REGBITS-1:0] rd_c,
  output logic               busy_a,
  output logic               busy_b,
  output logic               busy_c,
  output logic               sb_busy
);

  localparam int NREGS = 2 ** REGBITS;

  // Out-of-range latencies are clamped so the load value always fits the counter.
  localparam sb_cnt_t LOAD_VAL = (MC_LAT > MC_LAT_MAX) ? sb_cnt_t'(MC_LAT_MAX) :
                                 (MC_LAT < 1)          ? sb_cnt_t'(1) : sb_cnt_t'(MC_LAT);

  sb_cnt_t cnt [NREGS];

  // NOTE: the count array is reset like any other state, because a reset must
  // discard in-flight entries; leaving it unreset would release X stalls.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else if (pipe_en) begin
      // Entry 0 is never written, so it stays at its reset value of zero.
      for (int r = 1; r < NREGS; r++) begin
        if (issue && issue_rd == REGBITS'(r)) cnt[r] <= LOAD_VAL;
        else if (cnt[r] != '0)                cnt[r] <= cnt[r] - sb_cnt_t'(1);
      end
    end
  end

  assign busy_a = (cnt[rd_a] != '0);
  assign busy_b = (cnt[rd_b] != '0);
  assign busy_c = (cnt[rd_c] != '0);

  always_comb begin
    sb_busy = 1'b0;
    for (int r = 0; r < NREGS; r++) sb_busy = sb_busy | (cnt[r] != '0);
  end

endmodule

// File: rtl/forward_stall_unit.sv
// Forwarding-select and hazard-stall unit: nearest-stage forwarding, load-use
// detection and a multi-cycle scoreboard, with a registered hazard state and stall counter.
module forward_stall_unit
  import forward_stall_unit_pkg::*;
#(
  parameter int REGBITS = 5,
  parameter int NSTAGES = 2,
  parameter int MC_LAT  = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  forward_stall_unit_if.fu fsif
);

  localparam int SELW = $clog2(NSTAGES + 1);

  logic [SELW-1:0] porta_sel;
  logic [SELW-1:0] portb_sel;
  logic            lu;
  logic            sb_hit;
  logic            stall;
  logic            issue;
  logic            busy_rs;
  logic            busy_rt;
  logic            busy_rd;
  hazard_state_t   state_q;
  logic [31:0]     stall_cycles_q;

  // NOTE: every combinational output gets a default before the loop so that no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    porta_sel = '0;
    portb_sel = '0;
    // Walk from the farthest stage inward so the nearest matching stage is written last.
    for (int k = NSTAGES; k >= 1; k--) begin
      if (fsif.fwd_wen[k-1] && fsif.ex_rs != '0 &&
          fsif.fwd_reg[(k-1)*REGBITS +: REGBITS] == fsif.ex_rs)
        porta_sel = SELW'(k);
      if (fsif.fwd_wen[k-1] && fsif.ex_rt != '0 &&
          fsif.fwd_reg[(k-1)*REGBITS +: REGBITS] == fsif.ex_rt)
        portb_sel = SELW'(k);
    end
  end

  fwd_scoreboard #(
    .REGBITS (REGBITS),
    .MC_LAT  (MC_LAT)
  ) u_sb (
    .CLK      (CLK),
    .nRST     (nRST),
    .pipe_en  (fsif.pipe_en),
    .issue    (issue),
    .issue_rd (fsif.id_rd),
    .rd_a     (fsif.id_rs),
    .rd_b     (fsif.id_rt),
    .rd_c     (fsif.id_rd),
    .busy_a   (busy_rs),
    .busy_b   (busy_rt),
    .busy_c   (busy_rd),
    .sb_busy  (fsif.sb_busy)
  );

  assign lu = fsif.id_valid && fsif.ex_wen && fsif.ex_is_load && fsif.ex_rd != '0 &&
              (fsif.ex_rd == fsif.id_rs || fsif.ex_rd == fsif.id_rt);

  // A busy destination only matters for multi-cycle ops (WAW against an older mc op).
  assign sb_hit = fsif.id_valid && (busy_rs || busy_rt || (fsif.id_mc && busy_rd));

  assign stall = (lu || sb_hit) && !fsif.flush;

  assign issue = fsif.pipe_en && fsif.id_valid && fsif.id_mc && !stall &&
                 !fsif.flush && fsif.id_rd != '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
    end else if (fsif.pipe_en) begin
      if (lu)          state_q <= LU_STALL;
      else if (sb_hit) state_q <= SB_STALL;
      else             state_q <= RUN;
      if (stall) stall_cycles_q <= sat_inc32(stall_cycles_q);
    end
  end

  assign fsif.porta_sel    = porta_sel;
  assign fsif.portb_sel    = portb_sel;
  assign fsif.stall        = stall;
  assign fsif.stall_cycles = stall_cycles_q;
  assign fsif.hz_state     = state_q;

endmodule

// File: tb/tb_forward_stall_unit.sv
// Directed bench for forward_stall_unit: forwarding priority, load-use, scoreboard
// countdown, pipe hold, WAW/flush, async reset and counter saturation.
module tb_forward_stall_unit;
  import forward_stall_unit_pkg::*;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  forward_stall_unit_if #(.REGBITS(5), .NSTAGES(2)) fsif ();

  forward_stall_unit #(.REGBITS(5), .NSTAGES(2), .MC_LAT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fsif (fsif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle();
    fsif.pipe_en    = 1'b0;
    fsif.flush      = 1'b0;
    fsif.ex_rs      = '0;
    fsif.ex_rt      = '0;
    fsif.fwd_wen    = '0;
    fsif.fwd_reg    = '0;
    fsif.id_valid   = 1'b0;
    fsif.id_rs      = '0;
    fsif.id_rt      = '0;
    fsif.id_rd      = '0;
    fsif.id_mc      = 1'b0;
    fsif.ex_wen     = 1'b0;
    fsif.ex_is_load = 1'b0;
    fsif.ex_rd      = '0;
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue_mc(input logic [4:0] rd);
    fsif.pipe_en  = 1'b1;
    fsif.id_valid = 1'b1;
    fsif.id_mc    = 1'b1;
    fsif.id_rd    = rd;
    fsif.id_rs    = 5'd1;
    fsif.id_rt    = 5'd2;
    #1;
    step();
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b0;
    #12;
    total++;
    if (fsif.sb_busy !== 1'b0) begin
      bad++; $display("FAIL reset_sb_busy got=%b exp=0", fsif.sb_busy);
    end
    total++;
    if (fsif.stall_cycles !== 32'd0) begin
      bad++; $display("FAIL reset_stall_cycles got=%h exp=0", fsif.stall_cycles);
    end
    total++;
    if (fsif.hz_state !== RUN || fsif.stall !== 1'b0 || fsif.porta_sel !== 2'd0) begin
      bad++; $display("FAIL reset_state got=%0d/%b/%0d exp=RUN/0/0",
                      fsif.hz_state, fsif.stall, fsif.porta_sel);
    end
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  task automatic test_forwarding();
    idle();
    fsif.fwd_wen = 2'b11;
    fsif.fwd_reg = {5'd5, 5'd5};
    fsif.ex_rs   = 5'd5;
    fsif.ex_rt   = 5'd7;
    #1;
    total++;
    if (fsif.porta_sel !== 2'd1 || fsif.portb_sel !== 2'd0) begin
      bad++; $display("FAIL fwd_nearest got=%0d/%0d exp=1/0", fsif.porta_sel, fsif.portb_sel);
    end
    fsif.fwd_wen = 2'b10;
    #1;
    total++;
    if (fsif.porta_sel !== 2'd2) begin
      bad++; $display("FAIL fwd_far got=%0d exp=2", fsif.porta_sel);
    end
    fsif.fwd_wen = 2'b11;
    fsif.fwd_reg = {5'd5, 5'd3};
    fsif.ex_rs   = 5'd3;
    fsif.ex_rt   = 5'd5;
    #1;
    total++;
    if (fsif.porta_sel !== 2'd1 || fsif.portb_sel !== 2'd2) begin
      bad++; $display("FAIL fwd_split got=%0d/%0d exp=1/2", fsif.porta_sel, fsif.portb_sel);
    end
    fsif.fwd_reg = '0;
    fsif.ex_rs   = 5'd0;
    fsif.ex_rt   = 5'd0;
    #1;
    total++;
    if (fsif.porta_sel !== 2'd0 || fsif.portb_sel !== 2'd0) begin
      bad++; $display("FAIL fwd_r0 got=%0d/%0d exp=0/0", fsif.porta_sel, fsif.portb_sel);
    end
    idle();
    step();
  endtask

  task automatic test_load_use();
    idle();
    fsif.pipe_en    = 1'b1;
    fsif.ex_wen     = 1'b1;
    fsif.ex_is_load = 1'b1;
    fsif.ex_rd      = 5'd8;
    fsif.id_valid   = 1'b1;
    fsif.id_rs      = 5'd4;
    fsif.id_rt      = 5'd8;
    fsif.flush      = 1'b1;
    #1;
    total++;
    if (fsif.stall !== 1'b0) begin
      bad++; $display("FAIL lu_flushed got=%b exp=0", fsif.stall);
    end
    fsif.flush = 1'b0;
    #1;
    total++;
    if (fsif.stall !== 1'b1) begin
      bad++; $display("FAIL lu_stall got=%b exp=1", fsif.stall);
    end
    step();
    total++;
    if (fsif.hz_state !== LU_STALL || fsif.stall_cycles !== 32'd1) begin
      bad++; $display("FAIL lu_state got=%0d/%0d exp=%0d/1",
                      fsif.hz_state, fsif.stall_cycles, LU_STALL);
    end
    fsif.ex_rd = 5'd0;
    #1;
    total++;
    if (fsif.stall !== 1'b0) begin
      bad++; $display("FAIL lu_rd0 got=%b exp=0", fsif.stall);
    end
    step();
    total++;
    if (fsif.hz_state !== RUN || fsif.stall_cycles !== 32'd1) begin
      bad++; $display("FAIL lu_clear got=%0d/%0d exp=0/1", fsif.hz_state, fsif.stall_cycles);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    issue_mc(5'd9);
    total++;
    if (fsif.sb_busy !== 1'b1) begin
      bad++; $display("FAIL sb_busy_set got=%b exp=1", fsif.sb_busy);
    end
    fsif.id_mc = 1'b0;
    fsif.id_rs = 5'd9;
    fsif.id_rd = 5'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (fsif.stall !== 1'b1) begin
        bad++; $display("FAIL sb_count adv=%0d got=%b exp=1", i, fsif.stall);
      end
      step();
    end
    total++;
    if (fsif.stall !== 1'b0 || fsif.hz_state !== SB_STALL || fsif.stall_cycles !== 32'd5) begin
      bad++; $display("FAIL sb_release got=%b/%0d/%0d exp=0/%0d/5",
                      fsif.stall, fsif.hz_state, fsif.stall_cycles, SB_STALL);
    end
    step();
    total++;
    if (fsif.sb_busy !== 1'b0 || fsif.hz_state !== RUN) begin
      bad++; $display("FAIL sb_idle got=%b/%0d exp=0/0", fsif.sb_busy, fsif.hz_state);
    end
    idle();
  endtask

  task automatic test_pipe_hold();
    int stalled;
    idle();
    issue_mc(5'd9);
    fsif.id_mc = 1'b0;
    fsif.id_rs = 5'd9;
    stalled = 0;
    // Two advances, three held cycles, then advance until released (bounded).
    for (int c = 0; c < 12 && fsif.stall !== 1'b0; c++) begin
      fsif.pipe_en = !(c >= 2 && c < 5);
      #1;
      if (fsif.stall === 1'b1) stalled++;
      step();
    end
    total++;
    if (stalled != 7 || fsif.stall !== 1'b0) begin
      bad++; $display("FAIL hold_extend got=%0d/%b exp=7/0", stalled, fsif.stall);
    end
    total++;
    if (fsif.stall_cycles !== 32'd9) begin
      bad++; $display("FAIL hold_count got=%0d exp=9", fsif.stall_cycles);
    end
    idle();
  endtask

  task automatic test_waw_flush();
    idle();
    issue_mc(5'd9);
    fsif.pipe_en  = 1'b1;
    fsif.id_valid = 1'b1;
    fsif.id_mc    = 1'b1;
    fsif.id_rd    = 5'd9;
    fsif.id_rs    = 5'd1;
    fsif.id_rt    = 5'd2;
    #1;
    total++;
    if (fsif.stall !== 1'b1) begin
      bad++; $display("FAIL waw_stall got=%b exp=1", fsif.stall);
    end
    step();
    fsif.flush = 1'b1;
    #1;
    total++;
    if (fsif.stall !== 1'b0) begin
      bad++; $display("FAIL flush_stall got=%b exp=0", fsif.stall);
    end
    step();
    total++;
    if (dut.u_sb.cnt[9] !== 4'd2 || fsif.stall_cycles !== 32'd10) begin
      bad++; $display("FAIL flush_noissue got=%0d/%0d exp=2/10",
                      dut.u_sb.cnt[9], fsif.stall_cycles);
    end
    fsif.flush = 1'b0;
    fsif.id_mc = 1'b0;
    #1;
    total++;
    if (fsif.stall !== 1'b0) begin
      bad++; $display("FAIL non_mc_rd got=%b exp=0", fsif.stall);
    end
  endtask

  task automatic test_async_reset();
    fsif.pipe_en = 1'b0;
    #1;
    nRST = 1'b0;
    #1;
    total++;
    if (fsif.sb_busy !== 1'b0 || fsif.stall_cycles !== 32'd0 || fsif.hz_state !== RUN) begin
      bad++; $display("FAIL async_reset got=%b/%0d/%0d exp=0/0/0",
                      fsif.sb_busy, fsif.stall_cycles, fsif.hz_state);
    end
    #1;
    nRST = 1'b1;
    idle();
    fsif.pipe_en  = 1'b1;
    fsif.id_valid = 1'b1;
    fsif.id_rs    = 5'd9;
    #1;
    total++;
    if (fsif.stall !== 1'b0) begin
      bad++; $display("FAIL post_reset_read got=%b exp=0", fsif.stall);
    end
    step();
    idle();
  endtask

  task automatic test_saturation();
    idle();
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    fsif.pipe_en    = 1'b1;
    fsif.ex_wen     = 1'b1;
    fsif.ex_is_load = 1'b1;
    fsif.ex_rd      = 5'd8;
    fsif.id_valid   = 1'b1;
    fsif.id_rs      = 5'd8;
    step();
    total++;
    if (fsif.stall_cycles !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sat_reach got=%h exp=ffffffff", fsif.stall_cycles);
    end
    step();
    step();
    total++;
    if (fsif.stall_cycles !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sat_hold got=%h exp=ffffffff", fsif.stall_cycles);
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_scoreboard();
    test_pipe_hold();
    test_waw_flush();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
